ad7266_avg_decimator: RTL and testbench

//  Boxcar averager/decimator directly downstream of the AD7266 SPI driver. Consumes paired

---
 rtl/ad7266_avg_decimator.sv | 153 +++++++++++++++
 tb/tb_ad7266_avg_decimator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ad7266_avg_decimator.sv
// ad7266_avg_decimator
//   Boxcar averager/decimator for paired AD7266 channel A/B conversions.
//   Sums 2^n consecutive sample pairs (n = min(log2_n_in, MAX_LOG2_N), latched
//   at the start of each block), divides by shifting, and offers the result
//   through a valid/ready output register with sticky overrun reporting.
//
//   Build option: define AVG_ROUNDING_EN for round-half-up averaging;
//   otherwise the average is truncated toward zero.
//
// Ports
//   clk_in           system clock, rising edge
//   rst_n_in         asynchronous active-low reset
//   sample_valid_in  1-cycle strobe, s_data_A_in/s_data_B_in hold a new pair
//   s_data_A_in      channel A sample (unsigned)
//   s_data_B_in      channel B sample (unsigned)
//   log2_n_in        requested log2 decimation, clamped to MAX_LOG2_N
//   avg_A_out        averaged channel A
//   avg_B_out        averaged channel B
//   avg_valid_out    averaged pair available, held until accepted
//   avg_ready_in     consumer ready
//   overrun_out      sticky: a completed average was dropped
//   clr_overrun_in   synchronous clear of overrun_out
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no block in progress; next strobe starts a block and latches n
// ACCUM | block in progress; count_q pairs already summed into acc_*_q

module ad7266_avg_decimator #(
  parameter int DATA_WIDTH = 12,
  parameter int MAX_LOG2_N = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  sample_valid_in,
  input  logic [DATA_WIDTH-1:0] s_data_A_in,
  input  logic [DATA_WIDTH-1:0] s_data_B_in,
  input  logic [3:0]            log2_n_in,
  output logic [DATA_WIDTH-1:0] avg_A_out,
  output logic [DATA_WIDTH-1:0] avg_B_out,
  output logic                  avg_valid_out,
  input  logic                  avg_ready_in,
  output logic                  overrun_out,
  input  logic                  clr_overrun_in
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2_N;
  localparam int CNT_W = MAX_LOG2_N + 1;
  localparam int N_W   = $clog2(MAX_LOG2_N + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]       state_q;
  logic [N_W-1:0]   n_q;
  logic [CNT_W-1:0] count_q;
  logic [ACC_W-1:0] acc_a_q;
  logic [ACC_W-1:0] acc_b_q;

  logic [N_W-1:0]        n_clamped;
  logic [N_W-1:0]        n_sel;
  logic [ACC_W-1:0]      acc_next_a;
  logic [ACC_W-1:0]      acc_next_b;
  logic [ACC_W-1:0]      round_val;
  logic [ACC_W-1:0]      sum_a;
  logic [ACC_W-1:0]      sum_b;
  logic [DATA_WIDTH-1:0] result_a;
  logic [DATA_WIDTH-1:0] result_b;
  logic [CNT_W-1:0]      count_inc;
  logic                  complete;
  logic                  load_out;

  always_comb begin
    n_clamped = (log2_n_in > 4'(MAX_LOG2_N)) ? N_W'(MAX_LOG2_N) : N_W'(log2_n_in);
    // The first sample of a block uses the freshly clamped n; later ones the latched n.
    n_sel     = (state_q == IDLE) ? n_clamped : n_q;
    count_inc = count_q + CNT_W'(1);

    if (state_q == IDLE) begin
      acc_next_a = ACC_W'(s_data_A_in);
      acc_next_b = ACC_W'(s_data_B_in);
    end else begin
      acc_next_a = acc_a_q + ACC_W'(s_data_A_in);
      acc_next_b = acc_b_q + ACC_W'(s_data_B_in);
    end

`ifdef AVG_ROUNDING_EN
    round_val = (n_sel != '0) ? (ACC_W'(1) << (n_sel - N_W'(1))) : '0;
`else
    round_val = '0;
`endif

    // Worst case 2^MAX_LOG2_N full-scale samples plus round still fits ACC_W.
    sum_a    = acc_next_a + round_val;
    sum_b    = acc_next_b + round_val;
    result_a = DATA_WIDTH'(sum_a >> n_sel);
    result_b = DATA_WIDTH'(sum_b >> n_sel);

    complete = 1'b0;
    if (sample_valid_in) begin
      if (state_q == IDLE) complete = (n_clamped == '0);
      else                 complete = (count_inc == (CNT_W'(1) << n_q));
    end

    // Accept-and-reload in the same cycle is a legal load, not an overrun.
    load_out = complete && (!avg_valid_out || avg_ready_in);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      n_q     <= '0;
      count_q <= '0;
      acc_a_q <= '0;
      acc_b_q <= '0;
    end else if (sample_valid_in) begin
      if (state_q == IDLE) n_q <= n_clamped;
      if (complete) begin
        state_q <= IDLE;
        count_q <= '0;
        acc_a_q <= '0;
        acc_b_q <= '0;
      end else begin
        state_q <= ACCUM;
        count_q <= count_inc;
        acc_a_q <= acc_next_a;
        acc_b_q <= acc_next_b;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      avg_A_out     <= '0;
      avg_B_out     <= '0;
      avg_valid_out <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      if (load_out) begin
        avg_A_out     <= result_a;
        avg_B_out     <= result_b;
        avg_valid_out <= 1'b1;
      end else if (avg_ready_in) begin
        avg_valid_out <= 1'b0;
      end

      // A new drop takes priority over a clear in the same cycle.
      if (complete && !load_out)   overrun_out <= 1'b1;
      else if (clr_overrun_in)     overrun_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad7266_avg_decimator.sv
module tb_ad7266_avg_decimator;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        sample_valid_in = 1'b0;
  logic [11:0] s_data_A_in = '0;
  logic [11:0] s_data_B_in = '0;
  logic [3:0]  log2_n_in = '0;
  logic [11:0] avg_A_out;
  logic [11:0] avg_B_out;
  logic        avg_valid_out;
  logic        avg_ready_in = 1'b0;
  logic        overrun_out;
  logic        clr_overrun_in = 1'b0;

  int checks = 0;
  int errors = 0;

  ad7266_avg_decimator #(.DATA_WIDTH(12), .MAX_LOG2_N(4)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .sample_valid_in (sample_valid_in),
    .s_data_A_in     (s_data_A_in),
    .s_data_B_in     (s_data_B_in),
    .log2_n_in       (log2_n_in),
    .avg_A_out       (avg_A_out),
    .avg_B_out       (avg_B_out),
    .avg_valid_out   (avg_valid_out),
    .avg_ready_in    (avg_ready_in),
    .overrun_out     (overrun_out),
    .clr_overrun_in  (clr_overrun_in)
  );

  always #5 clk_in = ~clk_in;

  // Drives one strobe at a falling edge; returns at the next falling edge,
  // after the capturing rising edge, so outputs can be sampled directly.
  task automatic strobe(input logic [11:0] a, input logic [11:0] b);
    sample_valid_in = 1'b1;
    s_data_A_in     = a;
    s_data_B_in     = b;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++; if (avg_A_out !== 12'h000) begin errors++; $display("FAIL reset_A got %h exp 000", avg_A_out); end
    checks++; if (avg_B_out !== 12'h000) begin errors++; $display("FAIL reset_B got %h exp 000", avg_B_out); end
    checks++; if (avg_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", avg_valid_out); end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun_out); end
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_passthrough();
    log2_n_in    = 4'd0;
    avg_ready_in = 1'b1;
    strobe(12'h123, 12'hABC);
    checks++; if (avg_valid_out !== 1'b1) begin errors++; $display("FAIL pass_valid got %b exp 1", avg_valid_out); end
    checks++; if (avg_A_out !== 12'h123) begin errors++; $display("FAIL pass_A got %h exp 123", avg_A_out); end
    checks++; if (avg_B_out !== 12'hABC) begin errors++; $display("FAIL pass_B got %h exp abc", avg_B_out); end
    @(negedge clk_in);
    checks++; if (avg_valid_out !== 1'b0) begin errors++; $display("FAIL pass_valid_drop got %b exp 0", avg_valid_out); end
  endtask

  task automatic test_avg4();
    logic [11:0] exp_a;
`ifdef AVG_ROUNDING_EN
    exp_a = 12'd3;
`else
    exp_a = 12'd2;
`endif
    log2_n_in    = 4'd2;
    avg_ready_in = 1'b1;
    strobe(12'd1, 12'hFFF);
    strobe(12'd2, 12'hFFF);
    strobe(12'd3, 12'hFFF);
    checks++; if (avg_valid_out !== 1'b0) begin errors++; $display("FAIL avg4_early_valid got %b exp 0", avg_valid_out); end
    strobe(12'd4, 12'hFFF);
    checks++; if (avg_valid_out !== 1'b1) begin errors++; $display("FAIL avg4_valid got %b exp 1", avg_valid_out); end
    checks++; if (avg_A_out !== exp_a) begin errors++; $display("FAIL avg4_A got %h exp %h", avg_A_out, exp_a); end
    checks++; if (avg_B_out !== 12'hFFF) begin errors++; $display("FAIL avg4_B got %h exp fff", avg_B_out); end
    @(negedge clk_in);
  endtask

  // log2_n_in above MAX_LOG2_N clamps to 4, i.e. 16-sample blocks.
  task automatic test_max_clamp();
    log2_n_in    = 4'hF;
    avg_ready_in = 1'b1;
    for (int i = 0; i < 15; i++) strobe(12'hFFF, 12'hFFF);
    checks++; if (avg_valid_out !== 1'b0) begin errors++; $display("FAIL max_early_valid got %b exp 0", avg_valid_out); end
    strobe(12'hFFF, 12'hFFF);
    checks++; if (avg_valid_out !== 1'b1) begin errors++; $display("FAIL max_valid got %b exp 1", avg_valid_out); end
    checks++; if (avg_A_out !== 12'hFFF) begin errors++; $display("FAIL max_A got %h exp fff", avg_A_out); end
    checks++; if (avg_B_out !== 12'hFFF) begin errors++; $display("FAIL max_B got %h exp fff", avg_B_out); end
    @(negedge clk_in);
  endtask

  task automatic test_overrun();
    log2_n_in    = 4'd1;
    avg_ready_in = 1'b0;
    strobe(12'd10, 12'd30);
    strobe(12'd20, 12'd40);
    checks++; if (avg_A_out !== 12'd15) begin errors++; $display("FAIL ovr_first_A got %0d exp 15", avg_A_out); end
    strobe(12'd100, 12'd300);
    strobe(12'd200, 12'd400);
    checks++; if (avg_valid_out !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", avg_valid_out); end
    checks++; if (avg_A_out !== 12'd15) begin errors++; $display("FAIL ovr_held_A got %0d exp 15", avg_A_out); end
    checks++; if (avg_B_out !== 12'd35) begin errors++; $display("FAIL ovr_held_B got %0d exp 35", avg_B_out); end
    checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun_out); end
    clr_overrun_in = 1'b1;
    @(negedge clk_in);
    clr_overrun_in = 1'b0;
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun_out); end
    // A drop coinciding with a clear leaves overrun set.
    strobe(12'd1, 12'd1);
    clr_overrun_in = 1'b1;
    strobe(12'd1, 12'd1);
    clr_overrun_in = 1'b0;
    checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun_out); end
    checks++; if (avg_A_out !== 12'd15) begin errors++; $display("FAIL ovr_held2_A got %0d exp 15", avg_A_out); end
    clr_overrun_in = 1'b1;
    @(negedge clk_in);
    clr_overrun_in = 1'b0;
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL ovr_clear2 got %b exp 0", overrun_out); end
  endtask

  // Entered with valid=1 holding 15/35 and ready low.
  task automatic test_back_to_back();
    log2_n_in = 4'd1;
    strobe(12'd6, 12'd2);
    avg_ready_in = 1'b1;
    strobe(12'd8, 12'd4);
    checks++; if (avg_valid_out !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", avg_valid_out); end
    checks++; if (avg_A_out !== 12'd7) begin errors++; $display("FAIL b2b_A got %0d exp 7", avg_A_out); end
    checks++; if (avg_B_out !== 12'd3) begin errors++; $display("FAIL b2b_B got %0d exp 3", avg_B_out); end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun_out); end
    @(negedge clk_in);
    checks++; if (avg_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b exp 0", avg_valid_out); end
  endtask

  task automatic test_mid_change();
    log2_n_in    = 4'd2;
    avg_ready_in = 1'b1;
    strobe(12'd8, 12'd0);
    strobe(12'd8, 12'd4);
    log2_n_in = 4'd0;
    strobe(12'd8, 12'd8);
    checks++; if (avg_valid_out !== 1'b0) begin errors++; $display("FAIL mid_early_valid got %b exp 0", avg_valid_out); end
    strobe(12'd8, 12'd12);
    checks++; if (avg_valid_out !== 1'b1) begin errors++; $display("FAIL mid_valid got %b exp 1", avg_valid_out); end
    checks++; if (avg_A_out !== 12'd8) begin errors++; $display("FAIL mid_A got %0d exp 8", avg_A_out); end
    checks++; if (avg_B_out !== 12'd6) begin errors++; $display("FAIL mid_B got %0d exp 6", avg_B_out); end
    @(negedge clk_in);
    strobe(12'h5A5, 12'h0F0);
    checks++; if (avg_valid_out !== 1'b1) begin errors++; $display("FAIL mid_pass_valid got %b exp 1", avg_valid_out); end
    checks++; if (avg_A_out !== 12'h5A5) begin errors++; $display("FAIL mid_pass_A got %h exp 5a5", avg_A_out); end
    checks++; if (avg_B_out !== 12'h0F0) begin errors++; $display("FAIL mid_pass_B got %h exp 0f0", avg_B_out); end
  endtask

  task automatic test_reset_mid_block();
    log2_n_in    = 4'd2;
    avg_ready_in = 1'b1;
    strobe(12'd100, 12'd100);
    strobe(12'd100, 12'd100);
    rst_n_in = 1'b0;
    #1;
    checks++; if (avg_A_out !== 12'h000) begin errors++; $display("FAIL rstmid_A got %h exp 000", avg_A_out); end
    checks++; if (avg_B_out !== 12'h000) begin errors++; $display("FAIL rstmid_B got %h exp 000", avg_B_out); end
    checks++; if (avg_valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", avg_valid_out); end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    strobe(12'd4, 12'd1);
    strobe(12'd4, 12'd1);
    strobe(12'd4, 12'd1);
    checks++; if (avg_valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid got %b exp 0", avg_valid_out); end
    strobe(12'd4, 12'd1);
    checks++; if (avg_valid_out !== 1'b1) begin errors++; $display("FAIL rstmid_valid2 got %b exp 1", avg_valid_out); end
    checks++; if (avg_A_out !== 12'd4) begin errors++; $display("FAIL rstmid_A2 got %0d exp 4", avg_A_out); end
    checks++; if (avg_B_out !== 12'd1) begin errors++; $display("FAIL rstmid_B2 got %0d exp 1", avg_B_out); end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_passthrough();
    test_avg4();
    test_max_clamp();
    test_overrun();
    test_back_to_back();
    test_mid_change();
    test_reset_mid_block();
    repeat (2) @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
